// File: rtl/hilo_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hilo_muldiv_ctrl
//  Description : HI/LO sequencing controller. Accepts MULT/MULTU/DIV/DIVU/
//                MTHI/MTLO from EX, runs a fixed-latency multiply or a
//                1-bit/cycle restoring divide, and drives the HI/LO write port.
//  Revision    : 1.0 - initial release
// ============================================================================
module hilo_muldiv_ctrl #(
    parameter int MUL_LAT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    input  logic [2:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush,
    output logic        op_ready,
    output logic        busy,
    output logic [1:0]  hilo_we,
    output logic [31:0] hilo_hi,
    output logic [31:0] hilo_lo,
    output logic        done
);

    localparam logic [2:0] c_OP_MULT  = 3'b000;
    localparam logic [2:0] c_OP_MULTU = 3'b001;
    localparam logic [2:0] c_OP_DIV   = 3'b010;
    localparam logic [2:0] c_OP_DIVU  = 3'b011;
    localparam logic [2:0] c_OP_MTHI  = 3'b100;
    localparam logic [2:0] c_OP_MTLO  = 3'b101;

    // Multiply latency counter only needs to hold MUL_LAT-1.
    localparam int                 c_MCW       = (MUL_LAT < 2) ? 1 : $clog2(MUL_LAT);
    localparam logic [c_MCW-1:0]   c_MUL_INIT  = c_MCW'(MUL_LAT - 1);
    localparam logic [c_MCW-1:0]   c_MUL_LAST  = c_MCW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } state_t;

    state_t            r_state,  w_state_nxt;
    logic [c_MCW-1:0]  r_mcnt,   w_mcnt_nxt;
    logic [4:0]        r_dcnt,   w_dcnt_nxt;
    logic [31:0]       r_opa,    w_opa_nxt;    // mul operand A / dividend shifting into quotient
    logic [31:0]       r_opb,    w_opb_nxt;    // mul operand B / divisor magnitude
    logic [32:0]       r_rem,    w_rem_nxt;    // partial remainder
    logic [31:0]       r_raw_a,  w_raw_a_nxt;  // unmodified dividend for divide-by-zero result
    logic              r_msign,  w_msign_nxt;  // signed multiply
    logic              r_qneg,   w_qneg_nxt;
    logic              r_rneg,   w_rneg_nxt;
    logic              r_dbz,    w_dbz_nxt;
    logic [1:0]        r_we,     w_we_nxt;
    logic [31:0]       r_hi,     w_hi_nxt;
    logic [31:0]       r_lo,     w_lo_nxt;
    logic              r_done,   w_done_nxt;

    logic        w_accept;
    logic        w_a_neg, w_b_neg;
    logic [31:0] w_a_mag, w_b_mag;
    logic [31:0] w_mul_x, w_mul_y;
    logic        w_mul_sgn;
    logic [63:0] w_prod;
    logic [33:0] w_rem_sh, w_diff;
    logic        w_fits;
    logic [32:0] w_rem_step;
    logic [31:0] w_quo_step;
    logic [31:0] w_quo_fin, w_rem_fin;

    assign op_ready = (r_state == S_IDLE);
    assign busy     = ~op_ready;
    assign hilo_we  = r_we;
    assign hilo_hi  = r_hi;
    assign hilo_lo  = r_lo;
    assign done     = r_done;

    assign w_accept = op_valid & op_ready & ~flush & (op <= c_OP_MTLO);

    // op[0] distinguishes the unsigned variants of both multiply and divide.
    assign w_a_neg = ~op[0] & src_a[31];
    assign w_b_neg = ~op[0] & src_b[31];
    assign w_a_mag = w_a_neg ? (~src_a + 32'd1) : src_a;
    assign w_b_mag = w_b_neg ? (~src_b + 32'd1) : src_b;

    // A single-cycle multiply is written straight from IDLE, so it takes its
    // operands from the request; longer latencies use the latched operands.
    generate
        if (MUL_LAT == 1) begin : g_mul_direct
            assign w_mul_x   = src_a;
            assign w_mul_y   = src_b;
            assign w_mul_sgn = ~op[0];
        end else begin : g_mul_latched
            assign w_mul_x   = r_opa;
            assign w_mul_y   = r_opb;
            assign w_mul_sgn = r_msign;
        end
    endgenerate

    // Sign-extending to 64 bits makes the truncated product correct for both signednesses.
    assign w_prod = {{32{w_mul_sgn & w_mul_x[31]}}, w_mul_x} *
                    {{32{w_mul_sgn & w_mul_y[31]}}, w_mul_y};

    // One restoring step: shift in the next dividend bit and try to subtract.
    assign w_rem_sh   = {r_rem, r_opa[31]};
    assign w_diff     = w_rem_sh - {2'b00, r_opb};
    assign w_fits     = ~w_diff[33];
    assign w_rem_step = w_fits ? w_diff[32:0] : w_rem_sh[32:0];
    assign w_quo_step = {r_opa[30:0], w_fits};
    assign w_quo_fin  = r_qneg ? (~w_quo_step + 32'd1) : w_quo_step;
    assign w_rem_fin  = r_rneg ? (~w_rem_step[31:0] + 32'd1) : w_rem_step[31:0];

    // Next-state, datapath and registered-output logic.
    always_comb begin
        w_state_nxt = r_state;
        w_mcnt_nxt  = r_mcnt;
        w_dcnt_nxt  = r_dcnt;
        w_opa_nxt   = r_opa;
        w_opb_nxt   = r_opb;
        w_rem_nxt   = r_rem;
        w_raw_a_nxt = r_raw_a;
        w_msign_nxt = r_msign;
        w_qneg_nxt  = r_qneg;
        w_rneg_nxt  = r_rneg;
        w_dbz_nxt   = r_dbz;
        w_we_nxt    = 2'b00;
        w_hi_nxt    = r_hi;
        w_lo_nxt    = r_lo;
        w_done_nxt  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    case (op)
                        c_OP_MTHI: begin
                            w_we_nxt   = 2'b10;
                            w_hi_nxt   = src_a;
                            w_done_nxt = 1'b1;
                        end
                        c_OP_MTLO: begin
                            w_we_nxt   = 2'b01;
                            w_lo_nxt   = src_a;
                            w_done_nxt = 1'b1;
                        end
                        c_OP_MULT, c_OP_MULTU: begin
                            if (MUL_LAT == 1) begin
                                w_we_nxt   = 2'b11;
                                w_hi_nxt   = w_prod[63:32];
                                w_lo_nxt   = w_prod[31:0];
                                w_done_nxt = 1'b1;
                            end else begin
                                w_opa_nxt   = src_a;
                                w_opb_nxt   = src_b;
                                w_msign_nxt = ~op[0];
                                w_mcnt_nxt  = c_MUL_INIT;
                                w_state_nxt = S_MUL;
                            end
                        end
                        c_OP_DIV, c_OP_DIVU: begin
                            w_opa_nxt   = w_a_mag;
                            w_opb_nxt   = w_b_mag;
                            w_rem_nxt   = 33'd0;
                            w_raw_a_nxt = src_a;
                            w_qneg_nxt  = w_a_neg ^ w_b_neg;
                            w_rneg_nxt  = w_a_neg;
                            w_dbz_nxt   = (src_b == 32'd0);
                            w_dcnt_nxt  = 5'd31;
                            w_state_nxt = S_DIV;
                        end
                        default: ;
                    endcase
                end
            end
            S_MUL: begin
                if (r_mcnt == c_MUL_LAST) begin
                    w_we_nxt    = 2'b11;
                    w_hi_nxt    = w_prod[63:32];
                    w_lo_nxt    = w_prod[31:0];
                    w_done_nxt  = 1'b1;
                    w_mcnt_nxt  = '0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_mcnt_nxt = r_mcnt - c_MCW'(1);
                end
            end
            S_DIV: begin
                w_opa_nxt = w_quo_step;
                w_rem_nxt = w_rem_step;
                if (r_dcnt == 5'd0) begin
                    // The last step is folded straight into the output registers.
                    w_we_nxt    = 2'b11;
                    w_lo_nxt    = r_dbz ? 32'hFFFF_FFFF : w_quo_fin;
                    w_hi_nxt    = r_dbz ? r_raw_a : w_rem_fin;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_dcnt_nxt = r_dcnt - 5'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Flush cancels whatever is in flight; an already-visible write is unaffected.
        if (flush) begin
            w_state_nxt = S_IDLE;
            w_mcnt_nxt  = '0;
            w_dcnt_nxt  = 5'd0;
            w_we_nxt    = 2'b00;
            w_done_nxt  = 1'b0;
            w_hi_nxt    = r_hi;
            w_lo_nxt    = r_lo;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_mcnt  <= '0;
            r_dcnt  <= 5'd0;
            r_opa   <= 32'd0;
            r_opb   <= 32'd0;
            r_rem   <= 33'd0;
            r_raw_a <= 32'd0;
            r_msign <= 1'b0;
            r_qneg  <= 1'b0;
            r_rneg  <= 1'b0;
            r_dbz   <= 1'b0;
            r_we    <= 2'b00;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_mcnt  <= w_mcnt_nxt;
            r_dcnt  <= w_dcnt_nxt;
            r_opa   <= w_opa_nxt;
            r_opb   <= w_opb_nxt;
            r_rem   <= w_rem_nxt;
            r_raw_a <= w_raw_a_nxt;
            r_msign <= w_msign_nxt;
            r_qneg  <= w_qneg_nxt;
            r_rneg  <= w_rneg_nxt;
            r_dbz   <= w_dbz_nxt;
            r_we    <= w_we_nxt;
            r_hi    <= w_hi_nxt;
            r_lo    <= w_lo_nxt;
            r_done  <= w_done_nxt;
        end
    end

endmodule
`default_nettype wire
